// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter peripheral bus arbiter.
// Contents:
//   arb_state_e  - arbiter state encoding (IDLE, BUSY, RELEASE)
//   ADDR_W       - peripheral register address width
//   DATA_W       - peripheral data width
//   TIMEOUT_WORD - read data returned on an aborted transaction
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] TIMEOUT_WORD = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/counter_bus_arb_if.sv
// -----------------------------------------------------------------------------
// counter_bus_arb_if
// Groups the two requester ports and the shared peripheral bus.
// Signal names keep the i_/o_ direction as seen by the arbiter.
// Modports:
//   master - arbiter side (drives o_*, samples i_*)
//   slave  - environment side: requesters and peripheral (drives i_*)
// Signals:
//   i_reqN_select/wr/addr/data  requester N request and fields
//   o_reqN_data/ack/err         requester N completion
//   o_bus_select/wr, o_reg_addr, o_bus_data  peripheral request
//   i_bus_data, i_bus_ack       peripheral response
//   o_grant                     current / last owner of the bus
// -----------------------------------------------------------------------------
interface counter_bus_arb_if;
  import counter_pkg::*;

  logic              i_req0_select;
  logic              i_req0_wr;
  logic [ADDR_W-1:0] i_req0_addr;
  logic [DATA_W-1:0] i_req0_data;
  logic [DATA_W-1:0] o_req0_data;
  logic              o_req0_ack;
  logic              o_req0_err;

  logic              i_req1_select;
  logic              i_req1_wr;
  logic [ADDR_W-1:0] i_req1_addr;
  logic [DATA_W-1:0] i_req1_data;
  logic [DATA_W-1:0] o_req1_data;
  logic              o_req1_ack;
  logic              o_req1_err;

  logic              o_bus_select;
  logic              o_bus_wr;
  logic [ADDR_W-1:0] o_reg_addr;
  logic [DATA_W-1:0] o_bus_data;
  logic [DATA_W-1:0] i_bus_data;
  logic              i_bus_ack;
  logic              o_grant;

  modport master (
    input  i_req0_select, i_req0_wr, i_req0_addr, i_req0_data,
    input  i_req1_select, i_req1_wr, i_req1_addr, i_req1_data,
    input  i_bus_data, i_bus_ack,
    output o_req0_data, o_req0_ack, o_req0_err,
    output o_req1_data, o_req1_ack, o_req1_err,
    output o_bus_select, o_bus_wr, o_reg_addr, o_bus_data, o_grant
  );

  modport slave (
    output i_req0_select, i_req0_wr, i_req0_addr, i_req0_data,
    output i_req1_select, i_req1_wr, i_req1_addr, i_req1_data,
    output i_bus_data, i_bus_ack,
    input  o_req0_data, o_req0_ack, o_req0_err,
    input  o_req1_data, o_req1_ack, o_req1_err,
    input  o_bus_select, o_bus_wr, o_reg_addr, o_bus_data, o_grant
  );

endinterface

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
// Ports:
//   req0_i, req1_i  pending requests
//   last_grant_i    index of the port granted last time
//   grant_o         index of the winning port (meaningful when valid_o)
//   valid_o         at least one request is pending
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic valid_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    // On a tie the port that did not win last time goes next.
    if (req0_i && req1_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = req1_i;
    end
  end

endmodule

// File: rtl/counter_bus_arb.sv
// -----------------------------------------------------------------------------
// counter_bus_arb
// Shares the counter peripheral register bus between two requesters with
// round-robin priority. Fields are captured at grant, the bus is held until
// the peripheral acks, the winner gets a one-cycle ack with read data, and a
// single RELEASE cycle separates transactions.
// Ports:
//   i_sysclk    system clock
//   i_sysrst_n  asynchronous active-low reset
//   bus         counter_bus_arb_if.master (requesters + peripheral bus)
// Parameters:
//   TIMEOUT     BUSY cycles before abort (1..255), timeout build only
// Build option:
//   COUNTER_BUS_ARB_TIMEOUT_EN - adds the 8-bit timeout counter and the
//   o_reqN_err pulse; without it BUSY waits for the ack indefinitely.
// -----------------------------------------------------------------------------
module counter_bus_arb
  import counter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic               i_sysclk,
  input logic               i_sysrst_n,
  counter_bus_arb_if.master bus
);

  arb_state_e              state_q, state_d;
  logic                    sel_q, sel_d;
  logic                    wr_q, wr_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    grant_q, grant_d;
  // Separate from grant_q: o_grant resets to 0 while the pointer resets to 1
  // so that port 0 wins the first tie.
  logic                    last_q, last_d;
  logic [1:0]              ack_q, ack_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;

  logic [1:0]              req_sel;
  logic [1:0]              req_wr;
  logic [1:0][ADDR_W-1:0]  req_addr;
  logic [1:0][DATA_W-1:0]  req_wdata;
  logic                    pick;
  logic                    pick_valid;

  assign req_sel   = {bus.i_req1_select, bus.i_req0_select};
  assign req_wr    = {bus.i_req1_wr, bus.i_req0_wr};
  assign req_addr  = {bus.i_req1_addr, bus.i_req0_addr};
  assign req_wdata = {bus.i_req1_data, bus.i_req0_data};

  rr_arb2 u_rr_arb2 (
    .req0_i       (req_sel[0]),
    .req1_i       (req_sel[1]),
    .last_grant_i (last_q),
    .grant_o      (pick),
    .valid_o      (pick_valid)
  );

`ifdef COUNTER_BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] err_q, err_d;
`else
  localparam logic [7:0] TIMEOUT_UNUSED = 8'(TIMEOUT);
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_UNUSED;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = '0;
    rdata_d = '0;   // read data is only non-zero during the ack cycle
`ifdef COUNTER_BUS_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d   = 1'b1;
          wr_d    = req_wr[pick];
          addr_d  = req_addr[pick];
          wdata_d = req_wdata[pick];
          grant_d = pick;
          last_d  = pick;
          state_d = BUSY;
`ifdef COUNTER_BUS_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // Ack is checked first so a simultaneous ack beats the timeout.
        if (bus.i_bus_ack) begin
          sel_d            = 1'b0;
          wr_d             = 1'b0;
          ack_d[grant_q]   = 1'b1;
          rdata_d[grant_q] = wr_q ? '0 : bus.i_bus_data;
          state_d          = RELEASE;
        end
`ifdef COUNTER_BUS_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          sel_d            = 1'b0;
          wr_d             = 1'b0;
          ack_d[grant_q]   = 1'b1;
          err_d[grant_q]   = 1'b1;
          rdata_d[grant_q] = TIMEOUT_WORD;
          state_d          = RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      ack_q   <= '0;
      rdata_q <= '0;
`ifdef COUNTER_BUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
`ifdef COUNTER_BUS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.o_bus_select = sel_q;
  assign bus.o_bus_wr     = wr_q;
  assign bus.o_reg_addr   = addr_q;
  assign bus.o_bus_data   = wdata_q;
  assign bus.o_grant      = grant_q;
  assign bus.o_req0_ack   = ack_q[0];
  assign bus.o_req1_ack   = ack_q[1];
  assign bus.o_req0_data  = rdata_q[0];
  assign bus.o_req1_data  = rdata_q[1];
`ifdef COUNTER_BUS_ARB_TIMEOUT_EN
  assign bus.o_req0_err   = err_q[0];
  assign bus.o_req1_err   = err_q[1];
`else
  assign bus.o_req0_err   = 1'b0;
  assign bus.o_req1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_counter_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_counter_bus_arb
// Scoreboard bench for counter_bus_arb. Expected bus transactions and
// requester responses are queued when a request is issued; a peripheral
// model pops the bus queue when o_bus_select rises and a response monitor
// pops the response queue on each ack. Honours COUNTER_BUS_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_bus_arb;
  import counter_pkg::*;

  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_bus_arb_if bif();

  counter_bus_arb #(.TIMEOUT(TO)) dut (
    .i_sysclk   (clk),
    .i_sysrst_n (rst_n),
    .bus        (bif)
  );

  typedef struct {
    int          port;
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] data;
    int          lat;     // select cycles before ack minus one; <0 never acks
    logic [15:0] rdata;
  } bus_exp_t;

  typedef struct {
    int          port;
    logic [15:0] data;
    logic        err;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_txn(input int port, input logic wr, input logic [3:0] addr,
                            input logic [15:0] data, input int lat,
                            input logic [15:0] rdata, input bit has_rsp);
    bus_exp_t b;
    rsp_exp_t r;
    b.port = port; b.wr = wr; b.addr = addr; b.data = data; b.lat = lat; b.rdata = rdata;
    bus_q.push_back(b);
    if (has_rsp) begin
      r.port = port;
      if (lat >= 0) begin
        r.data = wr ? 16'h0000 : rdata;
        r.err  = 1'b0;
      end else begin
        r.data = 16'hDEAD;
        r.err  = 1'b1;
      end
      rsp_q.push_back(r);
    end
  endtask

  task automatic drive_req(input int port, input logic sel, input logic wr,
                           input logic [3:0] addr, input logic [15:0] data);
    if (port == 0) begin
      bif.i_req0_select = sel; bif.i_req0_wr = wr; bif.i_req0_addr = addr; bif.i_req0_data = data;
    end else begin
      bif.i_req1_select = sel; bif.i_req1_wr = wr; bif.i_req1_addr = addr; bif.i_req1_data = data;
    end
  endtask

  // Hold the request until the ack, drop it just after the edge ending RELEASE.
  task automatic req(input int port, input logic wr, input logic [3:0] addr, input logic [15:0] data);
    int n;
    drive_req(port, 1'b1, wr, addr, data);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port == 0 ? bif.o_req0_ack : bif.o_req1_ack) && n < 2000);
    if (n >= 2000) check_val($sformatf("ack_wait_p%0d", port), n, 0);
    @(posedge clk);
    #1;
    drive_req(port, 1'b0, 1'b0, 4'h0, 16'h0000);
  endtask

  // Peripheral model and bus-side scoreboard.
  bus_exp_t cur;
  logic     sel_prev;
  logic     active;
  int       sel_cnt;
  int       low_cnt;
  int       last_gap;
  int       exp_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      sel_prev       = 1'b0;
      active         = 1'b0;
      sel_cnt        = 0;
      low_cnt        = 0;
      bif.i_bus_ack  = 1'b0;
      bif.i_bus_data = 16'h5A5A;
    end else begin
      bif.i_bus_ack  = 1'b0;
      bif.i_bus_data = 16'h5A5A;
      if (bif.o_bus_select && !sel_prev) begin
        last_gap = low_cnt;
        low_cnt  = 0;
        sel_cnt  = 0;
        if (bus_q.size() == 0) begin
          check_val("bus_unexpected", 1, 0);
          active = 1'b0;
        end else begin
          cur    = bus_q.pop_front();
          active = 1'b1;
          check_val("grant", bif.o_grant, cur.port);
          check_val("bus_wr", bif.o_bus_wr, cur.wr);
          check_val("bus_addr", bif.o_reg_addr, cur.addr);
          check_val("bus_data", bif.o_bus_data, cur.data);
        end
      end
      if (!bif.o_bus_select && sel_prev && active) begin
        exp_len = (cur.lat >= 0) ? cur.lat + 1 : TO;
        check_val("sel_len", sel_cnt, exp_len);
        active = 1'b0;
      end
      if (bif.o_bus_select) begin
        sel_cnt++;
        if (active && cur.lat >= 0 && sel_cnt == cur.lat + 1) begin
          bif.i_bus_ack  = 1'b1;
          bif.i_bus_data = cur.rdata;
        end
      end else begin
        low_cnt++;
      end
      sel_prev = bif.o_bus_select;
    end
  end

  // Requester-side response scoreboard.
  rsp_exp_t    r_cur;
  logic [15:0] r_data;
  logic        r_err;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.o_req0_ack || bif.o_req1_ack) begin
        if (rsp_q.size() == 0) begin
          check_val("rsp_unexpected", {bif.o_req1_ack, bif.o_req0_ack}, 0);
        end else begin
          r_cur  = rsp_q.pop_front();
          r_data = (r_cur.port == 0) ? bif.o_req0_data : bif.o_req1_data;
          r_err  = (r_cur.port == 0) ? bif.o_req0_err  : bif.o_req1_err;
          check_val("ack_port", {bif.o_req1_ack, bif.o_req0_ack}, (r_cur.port == 0) ? 2 'b01 : 2'b10);
          check_val("rsp_data", r_data, r_cur.data);
          check_val("rsp_err", r_err, r_cur.err);
          $display("txn port=%0d data=%h err=%0b t=%0t", r_cur.port, r_data, r_err, $time);
        end
      end
      if ((bif.o_req0_err && !bif.o_req0_ack) || (bif.o_req1_err && !bif.o_req1_ack))
        check_val("err_without_ack", {bif.o_req1_err, bif.o_req0_err}, 0);
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_sel"},   bif.o_bus_select, 0);
    check_val({tag, "_wr"},    bif.o_bus_wr, 0);
    check_val({tag, "_addr"},  bif.o_reg_addr, 0);
    check_val({tag, "_data"},  bif.o_bus_data, 0);
    check_val({tag, "_grant"}, bif.o_grant, 0);
    check_val({tag, "_acks"},  {bif.o_req1_ack, bif.o_req0_ack}, 0);
    check_val({tag, "_errs"},  {bif.o_req1_err, bif.o_req0_err}, 0);
    check_val({tag, "_rd0"},   bif.o_req0_data, 0);
    check_val({tag, "_rd1"},   bif.o_req1_data, 0);
  endtask

  initial begin
    int n;
    drive_req(0, 1'b0, 1'b0, 4'h0, 16'h0000);
    drive_req(1, 1'b0, 1'b0, 4'h0, 16'h0000);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write, ack two cycles after select.
    expect_txn(0, 1'b1, 4'h2, 16'h1234, 2, 16'h5A5A, 1'b1);
    req(0, 1'b1, 4'h2, 16'h1234);

    // Single read returning BEEF.
    expect_txn(1, 1'b0, 4'h5, 16'h0000, 1, 16'hBEEF, 1'b1);
    req(1, 1'b0, 4'h5, 16'h0000);
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous requests: port 0 then port 1, one idle cycle between.
    expect_txn(0, 1'b1, 4'h7, 16'h0007, 1, 16'h5A5A, 1'b1);
    expect_txn(1, 1'b0, 4'h8, 16'h0000, 3, 16'hCAFE, 1'b1);
    fork
      req(0, 1'b1, 4'h7, 16'h0007);
      req(1, 1'b0, 4'h8, 16'h0000);
    join
    check_val("gap_after_release", last_gap, 2);
    repeat (2) @(posedge clk);
    #1;

    // Sustained contention: grants must alternate 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++)
      expect_txn(i % 2, (i % 3) == 0, 4'(i + 1), 16'(32'h1000 + i), i % 3, 16'(32'hA000 + i), 1'b1);
    fork
      begin
        for (int j = 0; j < 3; j++)
          req(0, ((2 * j) % 3) == 0, 4'(2 * j + 1), 16'(32'h1000 + 2 * j));
      end
      begin
        for (int k = 0; k < 3; k++)
          req(1, ((2 * k + 1) % 3) == 0, 4'(2 * k + 2), 16'(32'h1000 + 2 * k + 1));
      end
    join
    repeat (2) @(posedge clk);
    #1;

`ifdef COUNTER_BUS_ARB_TIMEOUT_EN
    // Peripheral never acks: abort after TO busy cycles with DEAD and err.
    expect_txn(0, 1'b0, 4'h3, 16'h0000, -1, 16'h0000, 1'b1);
    req(0, 1'b0, 4'h3, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
`endif

    // Reset in the middle of a never-acked transaction from port 0.
    expect_txn(0, 1'b1, 4'h9, 16'h9999, -1, 16'h0000, 1'b0);
    drive_req(0, 1'b1, 1'b1, 4'h9, 16'h9999);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.o_bus_select && n < 20);
    if (n >= 20) check_val("select_wait", n, 0);
`ifndef COUNTER_BUS_ARB_TIMEOUT_EN
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bif.o_bus_select) n++;
    end
    check_val("hold_no_timeout", n, 1000);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    drive_req(0, 1'b0, 1'b0, 4'h0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // After reset port 0 must win the tie again even though it owned last.
    expect_txn(0, 1'b1, 4'hA, 16'hAAAA, 0, 16'h5A5A, 1'b1);
    expect_txn(1, 1'b0, 4'hB, 16'h0000, 1, 16'h7777, 1'b1);
    fork
      req(0, 1'b1, 4'hA, 16'hAAAA);
      req(1, 1'b0, 4'hB, 16'h0000);
    join
    repeat (3) @(posedge clk);
    #1;

    check_val("bus_q_empty", bus_q.size(), 0);
    check_val("rsp_q_empty", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
